apb_slave_mem: RTL and testbench

- Peripheral-side APB completer that sits directly downstream of the address-decoding bridge.
- Consumes one bridge output group (select, write strobe, address, write data) and implements a word-addressed 32-bit register memory.
- Inserts a programmable number of wait states and returns read data and PREADY to the bridge.
- Four instances, one per decoded slave port, form the peripheral side of the APB subsystem.

---
 rtl/apb_slave_mem_if.sv | 28 ++
 rtl/apb_slave_mem.sv | 141 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus bundle between the address-decoding bridge and
// one peripheral-side register memory.
//   master modport (bridge): drives psel, penable, pwrite, paddr, pwdata and
//                            receives prdata, pready, pslverr.
//   slave modport (memory) : the mirror image.
interface apb_slave_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer implementing a word-addressed register memory
// with a programmable number of wait states.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset (clears outputs and all words)
//   bus  : apb_slave_mem_if.slave
//            in : psel, penable, pwrite, paddr, pwdata
//            out: prdata, pready, pslverr (all registered)
// Word index is paddr[$clog2(DEPTH)-1:0]; upper address bits are ignored.
// Optional feature macro: APB_SLV_ERR_EN. When defined, word indices at or
// above LIMIT are unmapped: pslverr is raised with pready, writes are dropped
// and reads return zero. When undefined, pslverr stays 0 and LIMIT has no
// effect.
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1,
  parameter int LIMIT       = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_slave_mem_if.slave       bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx_in;

  assign idx_in      = bus.paddr[IDX_W-1:0];
  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

  if (ADDR_W > IDX_W) begin : g_paddr_hi
    // Upper address bits select nothing inside this peripheral.
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^bus.paddr[ADDR_W-1:IDX_W];
  end

  // Index lies in the unmapped region (only ever true with the error feature).
  function automatic logic idx_err(input logic [IDX_W-1:0] i);
    return ERR_EN && (int'(i) >= LIMIT);
  endfunction

  // Read value presented on prdata: unmapped words read as zero.
  function automatic logic [DATA_W-1:0] rd_word(input logic [IDX_W-1:0] i);
    return idx_err(i) ? '0 : mem[i];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // Setup phase: capture the transfer; address/data changes later on
          // are ignored because everything below works from the latches.
          if (bus.psel && !bus.penable) begin
            idx_q    <= idx_in;
            wr_q     <= bus.pwrite;
            wdata_q  <= bus.pwdata;
            cnt      <= 4'(WAIT_STATES);
            state    <= ACCESS;
            pready_q <= (WAIT_STATES == 0);
            if (WAIT_STATES == 0) begin
              pslverr_q <= idx_err(idx_in);
              if (!bus.pwrite) begin
                prdata_q <= rd_word(idx_in);
              end
            end
          end
        end

        ACCESS: begin
          if (!bus.psel) begin
            // Abort: drop the transfer without touching memory.
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end else if (bus.penable) begin
            if (!pready_q) begin
              // Wait states: pready rises on the edge where the count expires,
              // so exactly WAIT_STATES access cycles see pready low.
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                pready_q  <= 1'b1;
                pslverr_q <= idx_err(idx_q);
                if (!wr_q) begin
                  prdata_q <= rd_word(idx_q);
                end
              end
            end else begin
              // Completion: the write lands here, before any following setup
              // edge, so an immediate read-back sees the new data.
              if (wr_q && !idx_err(idx_q)) begin
                mem[idx_q] <= wdata_q;
              end
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: three apb_slave_mem instances (WAIT_STATES 0, 1, 3)
// sharing one driven bus; psel is steered to one instance per transfer.
// A per-instance word array models the memory contents.
module tb_apb_slave_mem;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;
  localparam int LIMIT = 48;

`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  int          sel = 0;

  logic [31:0] prdata_a  [NDUT];
  logic        pready_a  [NDUT];
  logic        pslverr_a [NDUT];

  logic [31:0] model [NDUT][DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_slave_mem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    assign bus.psel    = psel && (sel == g);
    assign bus.penable = penable;
    assign bus.pwrite  = pwrite;
    assign bus.paddr   = paddr;
    assign bus.pwdata  = pwdata;
    assign prdata_a[g]  = bus.prdata;
    assign pready_a[g]  = bus.pready;
    assign pslverr_a[g] = bus.pslverr;

    apb_slave_mem #(
      .ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3), .LIMIT(LIMIT)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One APB transfer to instance d; checks latency, pslverr and read data
  // against the model and updates the model on a successful write.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input bit abort, output logic [31:0] rd);
    int idx;
    bit err;
    int waits;
    idx = int'(a) % DEPTH;
    err = ERR_EN && (idx >= LIMIT);
    rd  = '0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("idle_pready", 32'(pready_a[k]), 32'd0);
    sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    if (abort) begin
      chk("abort_pre_pready", 32'(pready_a[d]), 32'(ws_of(d) == 0));
      psel = 1'b0;
      @(negedge clk);
      chk("abort_pready", 32'(pready_a[d]), 32'd0);
      chk("abort_pslverr", 32'(pslverr_a[d]), 32'd0);
    end else begin
      penable = 1'b1;
      paddr   = 8'($urandom);
      pwdata  = $urandom;
      waits   = 0;
      while (pready_a[d] !== 1'b1 && waits < 20) begin
        waits++;
        @(negedge clk);
        paddr = 8'($urandom);
      end
      if (waits >= 20) begin
        chk("pready_timeout", 32'(waits), 32'(ws_of(d)));
      end else begin
        chk("wait_cycles", 32'(waits), 32'(ws_of(d)));
        chk("pslverr", 32'(pslverr_a[d]), 32'(err));
        if (!wr) begin
          rd = prdata_a[d];
          chk("prdata", rd, err ? 32'h0 : model[d][idx]);
        end else if (!err) begin
          model[d][idx] = wd;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  pool [8];
    logic [7:0]  a;
    int          d;

    pool = '{8'h31, 8'h05, 8'h45, 8'h30, 8'h2F, 8'hFF, 8'h3F, 8'h70};
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < DEPTH; i++) model[k][i] = '0;

    // Reset held for two cycles
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_prdata", prdata_a[k], 32'h0);
      chk("rst_pready", 32'(pready_a[k]), 32'd0);
      chk("rst_pslverr", 32'(pslverr_a[k]), 32'd0);
    end
    rst = 1'b1;

    xfer(1, 1'b0, 8'h00, 32'h0, 1'b0, rd);
    chk("read_after_reset", rd, 32'h0);
    idle(1);

    // Write then read, one wait state
    xfer(1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, rd);
    idle(1);
    xfer(1, 1'b0, 8'h05, 32'h0, 1'b0, rd);
    chk("rb_05", rd, 32'hDEADBEEF);
    idle(1);

    // Wait-state sweep at 0 and 3
    xfer(0, 1'b1, 8'h3F, 32'hFFFFFFFF, 1'b0, rd);
    xfer(0, 1'b0, 8'h3F, 32'h0, 1'b0, rd);
    chk("rb_3f_ws0", rd, 32'hFFFFFFFF);
    xfer(2, 1'b1, 8'h3F, 32'hFFFFFFFF, 1'b0, rd);
    xfer(2, 1'b0, 8'h3F, 32'h0, 1'b0, rd);
    chk("rb_3f_ws3", rd, 32'hFFFFFFFF);
    idle(1);

    // Aborted write leaves the word untouched
    xfer(1, 1'b1, 8'h0A, 32'h12345678, 1'b1, rd);
    idle(1);
    xfer(1, 1'b0, 8'h0A, 32'h0, 1'b0, rd);
    chk("rb_0a_abort", rd, 32'h0);

    // Back-to-back writes, second one wraps onto index 0
    xfer(1, 1'b1, 8'h00, 32'h1, 1'b0, rd);
    xfer(1, 1'b1, 8'h40, 32'h2, 1'b0, rd);
    xfer(1, 1'b0, 8'h00, 32'h0, 1'b0, rd);
    chk("rb_wrap", rd, 32'h2);
    idle(1);

    // Index 49: unmapped only when the error feature is built in
    xfer(1, 1'b1, 8'h31, 32'hA5A5A5A5, 1'b0, rd);
    xfer(1, 1'b0, 8'h31, 32'h0, 1'b0, rd);
    chk("rb_31", rd, ERR_EN ? 32'h0 : 32'hA5A5A5A5);
    idle(1);

    // Randomized traffic across all three instances
    for (int t = 0; t < 250; t++) begin
      d = int'($urandom_range(0, NDUT - 1));
      a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      xfer(d, 1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0), rd);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Asynchronous reset clears prdata and all memory
    xfer(1, 1'b1, 8'h0F, 32'hCAFEF00D, 1'b0, rd);
    xfer(1, 1'b0, 8'h0F, 32'h0, 1'b0, rd);
    chk("rb_0f", rd, 32'hCAFEF00D);
    idle(1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_prdata", prdata_a[1], 32'h0);
    chk("async_rst_pready", 32'(pready_a[1]), 32'd0);
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < DEPTH; i++) model[k][i] = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      xfer(k, 1'b0, 8'h0F, 32'h0, 1'b0, rd);
      chk("rb_0f_after_rst", rd, 32'h0);
      xfer(k, 1'b0, 8'h3F, 32'h0, 1'b0, rd);
      chk("rb_3f_after_rst", rd, 32'h0);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
